inference_request_payload_extractor: RTL and testbench
======================================================

Name: inference_request_payload_extractor

Overview:
- Upstream neighbour of the JPEG decode / tensor conversion pipeline.
- Takes whole inference-request packets (Ethernet + IPv4 + UDP + 12-byte request header) on AXI-Stream and strips a fixed HEADER_BYTES prefix.
- Re-aligns the remaining payload (the JPEG file) to byte lane 0 and emits it as a contiguous AXI-Stream packet with correct tkeep and tlast.
- Drops runt packets, i.e. packets that carry no payload bytes.

Parameters:
- TDATA_WIDTH, 256, stream data width in bits; must be a multiple of 8.
- TUSER_WIDTH, 128, sideband width in bits.
- HEADER_BYTES, 54, number of leading bytes to strip; must be at least 1.
- TKEEP_WIDTH, TDATA_WIDTH/8, localparam, bytes per beat.
- HDR_BEATS, HEADER_BYTES/TKEEP_WIDTH, localparam, full beats to discard.
- OFFSET, HEADER_BYTES%TKEEP_WIDTH, localparam, header bytes in the boundary beat.

Ports:
- axis_aclk  in  1  clock
- axis_reset  in  1  synchronous, active-high reset
- pkt_in_axis_tdata  in  TDATA_WIDTH  packet data; byte lane 0 is the first byte on the wire
- pkt_in_axis_tkeep  in  TKEEP_WIDTH  byte enables; all ones except on the last beat, where they are contiguous from lane 0
- pkt_in_axis_tuser  in  TUSER_WIDTH  sideband; only the value on the first beat is meaningful
- pkt_in_axis_tvalid  in  1
- pkt_in_axis_tready  out  1
- pkt_in_axis_tlast  in  1
- jpeg_out_axis_tdata  out  TDATA_WIDTH  re-aligned payload
- jpeg_out_axis_tkeep  out  TKEEP_WIDTH
- jpeg_out_axis_tuser  out  TUSER_WIDTH  tuser captured from the first input beat, held for every output beat of the packet
- jpeg_out_axis_tvalid  out  1
- jpeg_out_axis_tready  in  1
- jpeg_out_axis_tlast  out  1
- runt_drop  out  1  one-cycle pulse when a packet is discarded for having no payload

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - jpeg_out_axis_tvalid, tlast, tkeep, tdata, tuser all 0; runt_drop 0.
  - FSM goes to HEADER; beat counter 0; residual register cleared.
- Output stage:
  - One registered output stage.
  - pkt_in_axis_tready = !out_valid || jpeg_out_axis_tready, forced to 0 in FLUSH.
  - Output registers load only when they are empty or draining.
  - tdata, tkeep, tuser and tlast stay stable while tvalid is high and tready is low.
- Residual register: holds the TKEEP_WIDTH-OFFSET high bytes of the previous beat, plus their keep bits.
- Output beat composition: output tdata = {input low OFFSET bytes, residual}; tkeep is composed the same way.
- FSM states:
  - HEADER:
    - Count accepted beats; beats with index < HDR_BEATS are discarded.
    - Beat index HDR_BEATS (the boundary beat): load the residual from lanes OFFSET and up, capture tuser, go to PAYLOAD, emit nothing.
    - A tlast on a discarded beat, or a tlast on the boundary beat with no keep bits at or above lane OFFSET: discard the packet, pulse runt_drop, stay in HEADER with the counter cleared.
    - A tlast on the boundary beat with payload bytes present: go to FLUSH.
  - PAYLOAD, on each accepted beat:
    - Emit the composed beat.
    - If tlast is set and the input keep count is <= OFFSET: the emitted beat carries tlast; go to HEADER.
    - If tlast is set with keep count > OFFSET: emit the composed beat without tlast, load the new residual, go to FLUSH.
    - Otherwise: load the new residual.
  - FLUSH: emit the residual alone, shifted to lane 0, with tlast; go to HEADER once the emit is accepted.
- OFFSET == 0 (generate branch): after HDR_BEATS beats are discarded, beats pass through unchanged with one cycle of latency; FLUSH is never entered.
- Latency: first output beat appears 1 cycle after acceptance of the first post-boundary input beat.
- Throughput: one beat per cycle with no backpressure; one bubble on the input per packet when FLUSH is entered.
- Packets are back-to-back capable: HEADER accepts the next packet's first beat in the cycle after the previous packet's final output load.
- Reset mid-packet: the partial output is abandoned and tvalid drops the next cycle. The upstream is responsible for restarting on a packet boundary.

Optional Feature:
- Macro: INFERENCE_PAYLOAD_MAGIC_CHECK_EN.
- Defined:
  - Adds parameters MAGIC_OFFSET (default 42) and MAGIC_VALUE (16-bit, default 16'h4946). MAGIC_OFFSET+1 < HEADER_BYTES.
  - Header bytes MAGIC_OFFSET and MAGIC_OFFSET+1, in wire order, are compared against MAGIC_VALUE while in HEADER.
  - On mismatch the packet is consumed through tlast with no output, and the output port bad_magic (1-bit) pulses for one cycle at tlast.
  - No output beat of a rejected packet is ever emitted, because output only starts after the boundary beat.
- Undefined: no comparison is made, the bad_magic port is absent, and all non-runt packets are forwarded.

Test Plan:
- Payload passthrough (defaults, 256-bit): a 118-byte packet carrying payload bytes 0x00..0x3F on beats 1-3 (tkeep of last beat = 0x003FFFFF) -> 2 output beats. Beat 0 holds bytes 0x00..0x1F with tkeep 0xFFFFFFFF. Beat 1 holds 0x20..0x3F with tkeep 0xFFFFFFFF and tlast. tuser equals input beat 0's tuser.
- FLUSH path: a 120-byte packet -> 3 output beats; the last beat has tkeep 0x3 and tlast. pkt_in_axis_tready is low for exactly 1 cycle during FLUSH.
- Runt packets: a 54-byte packet -> no output and runt_drop pulses once. A 40-byte packet (tlast on beat 1) -> same result.
- Backpressure: jpeg_out_axis_tready toggles 1 cycle on / 1 cycle off over a 1000-byte packet -> the output byte stream is identical to the unstalled run, and output tdata is stable whenever tvalid is high and tready is low.
- Back-to-back and reset: two 118-byte packets with no gap -> 4 output beats and the tlast count is 2. Asserting axis_reset mid-payload -> tvalid is 0 the next cycle, and the following packet is extracted correctly.
- With INFERENCE_PAYLOAD_MAGIC_CHECK_EN defined: bytes 42-43 = 0x49,0x46 -> packet forwarded. Bytes 42-43 = 0x49,0x00 -> no output and bad_magic pulses once.

Source files
------------

// File: rtl/inference_request_payload_extractor.sv
// rtl/inference_request_payload_extractor.sv - strips HEADER_BYTES from each packet and re-aligns the payload to lane 0
// Optional header magic check: define INFERENCE_PAYLOAD_MAGIC_CHECK_EN (adds bad_magic port).
module inference_request_payload_extractor #(
    parameter int TDATA_WIDTH  = 256,
    parameter int TUSER_WIDTH  = 128,
    parameter int HEADER_BYTES = 54
`ifdef INFERENCE_PAYLOAD_MAGIC_CHECK_EN
    ,
    parameter int          MAGIC_OFFSET = 42,
    parameter logic [15:0] MAGIC_VALUE  = 16'h4946
`endif
) (
    input  logic                     axis_aclk,
    input  logic                     axis_reset,
    input  logic [TDATA_WIDTH-1:0]   pkt_in_axis_tdata,
    input  logic [TDATA_WIDTH/8-1:0] pkt_in_axis_tkeep,
    input  logic [TUSER_WIDTH-1:0]   pkt_in_axis_tuser,
    input  logic                     pkt_in_axis_tvalid,
    output logic                     pkt_in_axis_tready,
    input  logic                     pkt_in_axis_tlast,
    output logic [TDATA_WIDTH-1:0]   jpeg_out_axis_tdata,
    output logic [TDATA_WIDTH/8-1:0] jpeg_out_axis_tkeep,
    output logic [TUSER_WIDTH-1:0]   jpeg_out_axis_tuser,
    output logic                     jpeg_out_axis_tvalid,
    input  logic                     jpeg_out_axis_tready,
    output logic                     jpeg_out_axis_tlast,
    output logic                     runt_drop
`ifdef INFERENCE_PAYLOAD_MAGIC_CHECK_EN
    ,
    output logic                     bad_magic
`endif
);

    localparam int TKEEP_WIDTH = TDATA_WIDTH / 8;
    localparam int HDR_BEATS   = HEADER_BYTES / TKEEP_WIDTH;
    localparam int OFFSET      = HEADER_BYTES % TKEEP_WIDTH;
    localparam int CNT_W       = (HDR_BEATS > 0) ? $clog2(HDR_BEATS + 1) : 1;

    typedef enum logic [1:0] {ST_HEADER, ST_PAYLOAD, ST_FLUSH, ST_DROP} state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [TDATA_WIDTH-1:0] r_out_data;
    logic [TKEEP_WIDTH-1:0] r_out_keep;
    logic [TUSER_WIDTH-1:0] r_out_user;
    logic [TUSER_WIDTH-1:0] r_tuser;
    logic                   r_out_valid;
    logic                   r_out_last;
    logic                   r_runt_drop;

    logic w_out_ready;
    logic w_in_ready;
    logic w_in_fire;
    logic w_hdr_done;
    logic w_bad;

    assign w_out_ready        = !r_out_valid || jpeg_out_axis_tready;
    assign w_in_ready         = w_out_ready && (r_state != ST_FLUSH);
    assign w_in_fire          = pkt_in_axis_tvalid && w_in_ready;
    assign pkt_in_axis_tready = w_in_ready;

    assign jpeg_out_axis_tdata  = r_out_data;
    assign jpeg_out_axis_tkeep  = r_out_keep;
    assign jpeg_out_axis_tuser  = r_out_user;
    assign jpeg_out_axis_tvalid = r_out_valid;
    assign jpeg_out_axis_tlast  = r_out_last;
    assign runt_drop            = r_runt_drop;

`ifdef INFERENCE_PAYLOAD_MAGIC_CHECK_EN
    // The two magic bytes may straddle a beat boundary, so each is checked in its own beat.
    localparam int MB0_BEAT = MAGIC_OFFSET / TKEEP_WIDTH;
    localparam int MB0_LANE = MAGIC_OFFSET % TKEEP_WIDTH;
    localparam int MB1_BEAT = (MAGIC_OFFSET + 1) / TKEEP_WIDTH;
    localparam int MB1_LANE = (MAGIC_OFFSET + 1) % TKEEP_WIDTH;

    logic r_magic_bad;
    logic r_bad_magic;
    logic w_magic_mismatch;

    assign w_magic_mismatch = (r_state == ST_HEADER) &&
        (((r_cnt == CNT_W'(MB0_BEAT)) && (pkt_in_axis_tdata[MB0_LANE*8 +: 8] != MAGIC_VALUE[15:8])) ||
         ((r_cnt == CNT_W'(MB1_BEAT)) && (pkt_in_axis_tdata[MB1_LANE*8 +: 8] != MAGIC_VALUE[7:0])));
    assign w_bad     = r_magic_bad || w_magic_mismatch;
    assign bad_magic = r_bad_magic;

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            r_magic_bad <= 1'b0;
            r_bad_magic <= 1'b0;
        end else begin
            r_bad_magic <= w_in_fire && pkt_in_axis_tlast &&
                           ((r_state == ST_DROP) || (w_hdr_done && w_bad));
            if (w_in_fire && (r_state == ST_HEADER))
                r_magic_bad <= (pkt_in_axis_tlast || w_hdr_done) ? 1'b0 : w_bad;
        end
    end
`else
    assign w_bad = 1'b0;
`endif

    generate
        if (OFFSET == 0) begin : g_aligned
            // Header ends on a beat boundary: the last discarded beat is the decision point.
            assign w_hdr_done = (r_state == ST_HEADER) && (r_cnt == CNT_W'(HDR_BEATS - 1)) &&
                                !pkt_in_axis_tlast;

            always_ff @(posedge axis_aclk) begin
                if (axis_reset) begin
                    r_state     <= ST_HEADER;
                    r_cnt       <= '0;
                    r_out_data  <= '0;
                    r_out_keep  <= '0;
                    r_out_user  <= '0;
                    r_tuser     <= '0;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_runt_drop <= 1'b0;
                end else begin
                    r_runt_drop <= 1'b0;
                    if (r_out_valid && jpeg_out_axis_tready)
                        r_out_valid <= 1'b0;
                    case (r_state)
                        ST_HEADER: if (w_in_fire) begin
                            if (r_cnt == '0)
                                r_tuser <= pkt_in_axis_tuser;
                            if (w_hdr_done) begin
                                r_cnt   <= '0;
                                r_state <= w_bad ? ST_DROP : ST_PAYLOAD;
                            end else if (pkt_in_axis_tlast) begin
                                r_cnt       <= '0;
                                r_runt_drop <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                        ST_PAYLOAD: if (w_in_fire) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= pkt_in_axis_tdata;
                            r_out_keep  <= pkt_in_axis_tkeep;
                            r_out_user  <= r_tuser;
                            r_out_last  <= pkt_in_axis_tlast;
                            if (pkt_in_axis_tlast)
                                r_state <= ST_HEADER;
                        end
                        ST_DROP: if (w_in_fire && pkt_in_axis_tlast)
                            r_state <= ST_HEADER;
                        default: r_state <= ST_HEADER;
                    endcase
                end
            end
        end else begin : g_shift
            localparam int RES_BYTES = TKEEP_WIDTH - OFFSET;

            logic [RES_BYTES*8-1:0] r_res_data;
            logic [RES_BYTES-1:0]   r_res_keep;
            logic                   w_has_payload;

            // Contiguous tkeep: any bit at or above OFFSET means the beat spills into a new residual.
            assign w_has_payload = |pkt_in_axis_tkeep[TKEEP_WIDTH-1:OFFSET];
            assign w_hdr_done    = (r_state == ST_HEADER) && (r_cnt == CNT_W'(HDR_BEATS)) &&
                                   !(pkt_in_axis_tlast && !w_has_payload);

            always_ff @(posedge axis_aclk) begin
                if (axis_reset) begin
                    r_state     <= ST_HEADER;
                    r_cnt       <= '0;
                    r_out_data  <= '0;
                    r_out_keep  <= '0;
                    r_out_user  <= '0;
                    r_tuser     <= '0;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_runt_drop <= 1'b0;
                    r_res_data  <= '0;
                    r_res_keep  <= '0;
                end else begin
                    r_runt_drop <= 1'b0;
                    if (r_out_valid && jpeg_out_axis_tready)
                        r_out_valid <= 1'b0;
                    case (r_state)
                        ST_HEADER: if (w_in_fire) begin
                            if (r_cnt == '0)
                                r_tuser <= pkt_in_axis_tuser;
                            if (w_hdr_done) begin
                                r_cnt      <= '0;
                                r_res_data <= pkt_in_axis_tdata[TDATA_WIDTH-1:OFFSET*8];
                                r_res_keep <= pkt_in_axis_tkeep[TKEEP_WIDTH-1:OFFSET];
                                if (w_bad)
                                    r_state <= pkt_in_axis_tlast ? ST_HEADER : ST_DROP;
                                else
                                    r_state <= pkt_in_axis_tlast ? ST_FLUSH : ST_PAYLOAD;
                            end else if (pkt_in_axis_tlast) begin
                                r_cnt       <= '0;
                                r_runt_drop <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                        ST_PAYLOAD: if (w_in_fire) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= {pkt_in_axis_tdata[OFFSET*8-1:0], r_res_data};
                            r_out_keep  <= {pkt_in_axis_tkeep[OFFSET-1:0], r_res_keep};
                            r_out_user  <= r_tuser;
                            r_out_last  <= pkt_in_axis_tlast && !w_has_payload;
                            r_res_data  <= pkt_in_axis_tdata[TDATA_WIDTH-1:OFFSET*8];
                            r_res_keep  <= pkt_in_axis_tkeep[TKEEP_WIDTH-1:OFFSET];
                            if (pkt_in_axis_tlast)
                                r_state <= w_has_payload ? ST_FLUSH : ST_HEADER;
                        end
                        ST_FLUSH: if (w_out_ready) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= {{(OFFSET*8){1'b0}}, r_res_data};
                            r_out_keep  <= {{OFFSET{1'b0}}, r_res_keep};
                            r_out_user  <= r_tuser;
                            r_out_last  <= 1'b1;
                            r_state     <= ST_HEADER;
                        end
                        ST_DROP: if (w_in_fire && pkt_in_axis_tlast)
                            r_state <= ST_HEADER;
                        default: r_state <= ST_HEADER;
                    endcase
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_inference_request_payload_extractor.sv
// tb/tb_inference_request_payload_extractor.sv - directed self-checking bench for the payload extractor
module tb_inference_request_payload_extractor;

    localparam int DW = 256;
    localparam int KW = 32;
    localparam int UW = 128;
    localparam int HB = 54;

    localparam logic [UW-1:0] U1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [UW-1:0] U2 = 128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_0F0F;
    localparam logic [UW-1:0] U3 = 128'h0BAD_CAFE_0000_0001_0000_0002_0000_0003;

    logic          clk = 1'b0;
    logic          axis_reset = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic [KW-1:0] in_keep = '0;
    logic [UW-1:0] in_user = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic [KW-1:0] out_keep;
    logic [UW-1:0] out_user;
    logic          out_valid;
    logic          out_last;
    logic          out_tready = 1'b1;
    logic          runt_drop;
    bit            bp_en = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;
    int runt_cnt = 0;
    int rdy_low = 0;

    logic [DW-1:0] cap_data[$];
    logic [KW-1:0] cap_keep[$];
    logic          cap_last[$];
    logic [UW-1:0] cap_user[$];

    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_data;
    logic [KW-1:0] stall_keep;
    logic          stall_last;

    always #5 clk = ~clk;

    inference_request_payload_extractor dut (
        .axis_aclk            (clk),
        .axis_reset           (axis_reset),
        .pkt_in_axis_tdata    (in_data),
        .pkt_in_axis_tkeep    (in_keep),
        .pkt_in_axis_tuser    (in_user),
        .pkt_in_axis_tvalid   (in_valid),
        .pkt_in_axis_tready   (in_ready),
        .pkt_in_axis_tlast    (in_last),
        .jpeg_out_axis_tdata  (out_data),
        .jpeg_out_axis_tkeep  (out_keep),
        .jpeg_out_axis_tuser  (out_user),
        .jpeg_out_axis_tvalid (out_valid),
        .jpeg_out_axis_tready (out_tready),
        .jpeg_out_axis_tlast  (out_last),
        .runt_drop            (runt_drop)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (bp_en) out_tready = ~out_tready;
        else       out_tready = 1'b1;
    end

    always @(negedge clk) begin
        if (!axis_reset) begin
            if (out_valid && out_tready) begin
                cap_data.push_back(out_data);
                cap_keep.push_back(out_keep);
                cap_last.push_back(out_last);
                cap_user.push_back(out_user);
            end
            if (runt_drop) runt_cnt++;
            if (!in_ready) rdy_low++;
            if (stall_prev) begin
                check("stall_valid", {255'b0, out_valid}, 1);
                check("stall_data", out_data, stall_data);
                check("stall_keep", {224'b0, out_keep}, {224'b0, stall_keep});
                check("stall_last", {255'b0, out_last}, {255'b0, stall_last});
            end
            stall_prev = out_valid && !out_tready;
            stall_data = out_data;
            stall_keep = out_keep;
            stall_last = out_last;
        end else begin
            stall_prev = 1'b0;
        end
    end

    function automatic logic [7:0] pkt_byte(input int i, input int seed);
        if (i < HB) return 8'hC0 ^ 8'(i);
        return 8'(i - HB + seed);
    endfunction

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                             input logic [UW-1:0] u);
        int tries;
        bit acc;
        tries = 0;
        acc = 1'b0;
        in_data = d;
        in_keep = k;
        in_last = l;
        in_user = u;
        in_valid = 1'b1;
        while (!acc && tries < 500) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        if (!acc) check("in_accept_timeout", 0, 1);
    endtask

    task automatic send_pkt(input int n, input int seed, input logic [UW-1:0] u, input int lim);
        int nb;
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        nb = (n + KW - 1) / KW;
        for (int b = 0; b < nb && b < lim; b++) begin
            d = '0;
            k = '0;
            for (int l = 0; l < KW; l++) begin
                if (b * KW + l < n) begin
                    d[l*8 +: 8] = pkt_byte(b * KW + l, seed);
                    k[l] = 1'b1;
                end
            end
            send_beat(d, k, (b == nb - 1), (b == 0) ? u : ~u);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic check_out(input int first, input int n, input int seed, input logic [UW-1:0] u,
                             input string tag);
        int plen;
        int nb;
        logic [DW-1:0] ed;
        logic [DW-1:0] m;
        logic [KW-1:0] ek;
        plen = n - HB;
        nb = (plen + KW - 1) / KW;
        for (int j = 0; j < nb && first + j < cap_data.size(); j++) begin
            ed = '0;
            m = '0;
            ek = '0;
            for (int l = 0; l < KW; l++) begin
                if (j * KW + l < plen) begin
                    ed[l*8 +: 8] = pkt_byte(HB + j * KW + l, seed);
                    m[l*8 +: 8] = 8'hFF;
                    ek[l] = 1'b1;
                end
            end
            check($sformatf("%s_b%0d_data", tag, j), cap_data[first+j] & m, ed);
            check($sformatf("%s_b%0d_keep", tag, j), {224'b0, cap_keep[first+j]}, {224'b0, ek});
            check($sformatf("%s_b%0d_last", tag, j), {255'b0, cap_last[first+j]}, (j == nb - 1) ? 1 : 0);
            check($sformatf("%s_b%0d_user", tag, j), {128'b0, cap_user[first+j]}, {128'b0, u});
        end
    endtask

    task automatic clear_cap();
        cap_data.delete();
        cap_keep.delete();
        cap_last.delete();
        cap_user.delete();
    endtask

    task automatic drain(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    int nlast;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {255'b0, out_valid}, 0);
        check("rst_last", {255'b0, out_last}, 0);
        check("rst_keep", {224'b0, out_keep}, 0);
        check("rst_data", out_data, 0);
        check("rst_user", {128'b0, out_user}, 0);
        check("rst_runt", {255'b0, runt_drop}, 0);
        axis_reset = 1'b0;
        drain(2);

        clear_cap();
        runt_cnt = 0;
        send_pkt(118, 0, U1, 99);
        drain(20);
        check("pass_beats", cap_data.size(), 2);
        check_out(0, 118, 0, U1, "pass");
        check("pass_runt", runt_cnt, 0);

        clear_cap();
        rdy_low = 0;
        send_pkt(120, 0, U2, 99);
        drain(20);
        check("flush_beats", cap_data.size(), 3);
        check_out(0, 120, 0, U2, "flush");
        check("flush_rdy_low", rdy_low, 1);

        clear_cap();
        runt_cnt = 0;
        send_pkt(54, 0, U1, 99);
        drain(20);
        check("runt54_beats", cap_data.size(), 0);
        check("runt54_pulse", runt_cnt, 1);

        clear_cap();
        runt_cnt = 0;
        send_pkt(40, 0, U1, 99);
        drain(20);
        check("runt40_beats", cap_data.size(), 0);
        check("runt40_pulse", runt_cnt, 1);

        clear_cap();
        send_pkt(1000, 7, U3, 99);
        drain(20);
        check("big_beats", cap_data.size(), 30);
        check_out(0, 1000, 7, U3, "big");

        clear_cap();
        bp_en = 1'b1;
        send_pkt(1000, 7, U3, 99);
        drain(40);
        bp_en = 1'b0;
        drain(4);
        check("bp_beats", cap_data.size(), 30);
        check_out(0, 1000, 7, U3, "bp");

        clear_cap();
        send_pkt(118, 0, U1, 99);
        send_pkt(118, 8'h80, U2, 99);
        drain(20);
        check("b2b_beats", cap_data.size(), 4);
        nlast = 0;
        foreach (cap_last[i]) if (cap_last[i]) nlast++;
        check("b2b_tlast_cnt", nlast, 2);
        check_out(0, 118, 0, U1, "b2b0");
        check_out(2, 118, 8'h80, U2, "b2b1");

        clear_cap();
        send_pkt(118, 8'h20, U3, 3);
        check("rstmid_pre_valid", {255'b0, out_valid}, 1);
        axis_reset = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid_valid", {255'b0, out_valid}, 0);
        axis_reset = 1'b0;
        drain(2);
        clear_cap();
        send_pkt(118, 8'h10, U1, 99);
        drain(20);
        check("rstmid_beats", cap_data.size(), 2);
        check_out(0, 118, 8'h10, U1, "rstmid");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
